// File: rtl/preprocess_pkg.sv
// Shared types and sizing helpers for the line-buffer preprocess sequencer.
package preprocess_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN,
        ST_FETCH,
        ST_DONE
    } ctrl_state_e;

    localparam int unsigned DEF_MAX_ROW = 360;
    localparam int unsigned DEF_MAX_COL = 540;

    function automatic int unsigned addr_w(input int unsigned rows, input int unsigned cols);
        return $clog2(rows * cols);
    endfunction

endpackage

// File: rtl/preprocess_ctrl_if.sv
// Linear read-request channel between the sequencer and the memory controller.
interface preprocess_ctrl_if #(
    parameter int unsigned ADDR_W = 18
) ();

    logic              mem_rd_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_rdy_i;
    logic              mem_rvalid_i;

    modport master (
        output mem_rd_o,
        output mem_addr_o,
        input  mem_rdy_i,
        input  mem_rvalid_i
    );

    modport slave (
        input  mem_rd_o,
        input  mem_addr_o,
        output mem_rdy_i,
        output mem_rvalid_i
    );

endinterface

// File: rtl/preprocess_rd_gen.sv
// Read issue/return tracker: issues target_i linear reads and flags the final return.
module preprocess_rd_gen #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned CNT_W  = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              clear_addr_i,
    input  logic [CNT_W-1:0]  target_i,
    input  logic              count_en_i,
    input  logic              rdy_i,
    input  logic              rvalid_i,
    output logic              rd_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              fill_done_o
);

    logic [CNT_W-1:0]  issue_q, issue_d;
    logic [CNT_W-1:0]  ret_q, ret_d;
    logic [CNT_W-1:0]  target_q, target_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              accept;
    logic              ret_ev;

    assign accept      = rd_q && rdy_i;
    assign ret_ev      = count_en_i && rvalid_i;
    // Final return of the fill completes the phase in the same cycle it arrives.
    assign fill_done_o = ret_ev && (ret_q == target_q - CNT_W'(1));
    assign rd_o        = rd_q;
    assign addr_o      = addr_q;

    always_comb begin
        issue_d  = issue_q;
        ret_d    = ret_q;
        target_d = target_q;
        addr_d   = addr_q;
        rd_d     = rd_q;
        if (load_i) begin
            issue_d  = '0;
            ret_d    = '0;
            target_d = target_i;
            rd_d     = 1'b1;
            if (clear_addr_i) begin
                addr_d = '0;
            end
        end else begin
            if (accept) begin
                issue_d = issue_q + CNT_W'(1);
                addr_d  = addr_q + ADDR_W'(1);
                if (issue_q + CNT_W'(1) == target_q) begin
                    rd_d = 1'b0;
                end
            end
            if (ret_ev) begin
                ret_d = ret_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_q  <= '0;
            ret_q    <= '0;
            target_q <= '0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
        end else begin
            issue_q  <= issue_d;
            ret_q    <= ret_d;
            target_q <= target_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
        end
    end

endmodule

// File: rtl/preprocess_ctrl.sv
// Frame sequencer: primes three row buffers, then alternates core runs with single-row refills.
module preprocess_ctrl
    import preprocess_pkg::*;
#(
    parameter int unsigned MAX_ROW = DEF_MAX_ROW,
    parameter int unsigned MAX_COL = DEF_MAX_COL,
    parameter int unsigned ADDR_W  = addr_w(MAX_ROW, MAX_COL)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    preprocess_ctrl_if.master     mem_if,
    output logic                  core_run_o,
    input  logic                  core_done_i,
    output logic [1:0]            row_phase_o,
    output logic [ADDR_W-1:0]     out_row_o
);

    localparam int unsigned CNT_W = $clog2(3 * MAX_COL + 1);
    localparam logic [CNT_W-1:0]  PRIME_TGT = CNT_W'(3 * MAX_COL);
    localparam logic [CNT_W-1:0]  FETCH_TGT = CNT_W'(MAX_COL);
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(MAX_ROW - 3);

    ctrl_state_e       state_q;
    logic              busy_q;
    logic              done_q;
    logic              core_run_q;
    logic [1:0]        row_phase_q;
    logic [ADDR_W-1:0] out_row_q;

    logic              start_acc;
    logic              row_end;
    logic              load;
    logic              count_en;
    logic              fill_done;
    logic [CNT_W-1:0]  target;

    assign start_acc = (state_q == ST_IDLE) && start_i;
    assign row_end   = (state_q == ST_RUN) && core_done_i;
    // Refill load is issued on the RUN exit edge so FETCH requests start the next cycle.
    assign load      = start_acc || (row_end && (out_row_q != LAST_ROW));
    assign count_en  = (state_q == ST_PRIME) || (state_q == ST_FETCH);
    assign target    = (state_q == ST_IDLE) ? PRIME_TGT : FETCH_TGT;

    preprocess_rd_gen #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_rd_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (load),
        .clear_addr_i (start_acc),
        .target_i     (target),
        .count_en_i   (count_en),
        .rdy_i        (mem_if.mem_rdy_i),
        .rvalid_i     (mem_if.mem_rvalid_i),
        .rd_o         (mem_if.mem_rd_o),
        .addr_o       (mem_if.mem_addr_o),
        .fill_done_o  (fill_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            core_run_q  <= 1'b0;
            row_phase_q <= '0;
            out_row_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q     <= ST_PRIME;
                        busy_q      <= 1'b1;
                        row_phase_q <= '0;
                        out_row_q   <= '0;
                    end
                end
                ST_PRIME, ST_FETCH: begin
                    if (fill_done) begin
                        state_q    <= ST_RUN;
                        core_run_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (core_done_i) begin
                        core_run_q <= 1'b0;
                        if (out_row_q == LAST_ROW) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q     <= ST_FETCH;
                            out_row_q   <= out_row_q + ADDR_W'(1);
                            row_phase_q <= (row_phase_q == 2'd2) ? 2'd0 : row_phase_q + 2'd1;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign core_run_o  = core_run_q;
    assign row_phase_o = row_phase_q;
    assign out_row_o   = out_row_q;

endmodule
